uart_cmd_rx: RTL and testbench
==============================

UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 434, giving i_clk cycles per UART bit (50 MHz / 115200 baud); legal range is 8..65535.
REQ-002 The module SHALL have port i_clk, input, 1 bit: the single clock, 50 MHz system domain.
REQ-003 The module SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port i_uart_rx, input, 1 bit: asynchronous UART line, idle high, 8N1, LSB first.
REQ-005 The module SHALL have port o_byte_valid, output, 1 bit: one-cycle pulse when a received byte is good.
REQ-006 The module SHALL have port o_byte, output, 8 bits: last good byte, held until the next good byte.
REQ-007 The module SHALL have port o_wr_en, output, 1 bit: one-cycle register-write strobe.
REQ-008 The module SHALL have port o_wr_addr, output, 4 bits: write address, held until the next write.
REQ-009 The module SHALL have port o_wr_data, output, 32 bits: write data, held until the next write.
REQ-010 The module SHALL have port o_sync, output, 1 bit: one-cycle PPS re-sync request pulse.
REQ-011 The module SHALL have port o_err, output, 1 bit: one-cycle pulse on a framing error or a command syntax error.

Function -- byte receiver
REQ-012 i_uart_rx SHALL pass through a 2-FF synchronizer; all RX logic SHALL use only the synchronized value.
REQ-013 RX FSM states SHALL be R_IDLE, R_START, R_DATA, R_STOP and R_WAIT_HI.
REQ-014 In R_IDLE, a synchronized falling edge (high to low) SHALL enter R_START.
REQ-015 In R_START, the line SHALL be re-sampled after CLKS_PER_BIT/2 cycles (integer divide):
- low: enter R_DATA;
- high: false start, return to R_IDLE with no pulse.
REQ-016 In R_DATA, 8 bits SHALL be sampled LSB first, one every CLKS_PER_BIT cycles, starting from the start-bit centre.
REQ-017 In R_STOP, the stop bit SHALL be sampled CLKS_PER_BIT cycles after bit 7:
- high: o_byte updates and o_byte_valid pulses in the same cycle, then R_IDLE;
- low: framing error; the byte is discarded, o_err pulses, and the FSM enters R_WAIT_HI.
REQ-018 R_WAIT_HI SHALL stay until the synchronized line is high, then go to R_IDLE; this prevents break conditions from re-triggering reception.

Function -- command parser
REQ-019 The parser SHALL consume only good bytes, one per o_byte_valid.
REQ-020 Parser states SHALL be P_IDLE, P_ADDR, P_DATA and P_EOL.
REQ-021 Command grammar SHALL be:
- write: 'W'(0x57), 1 hex address digit, 8 hex data digits MSB first, CR(0x0D);
- sync: 'S'(0x53), CR.
REQ-022 Hex digits SHALL be 0-9, A-F and a-f.
REQ-023 In P_IDLE:
- 'W' SHALL go to P_ADDR;
- 'S' SHALL go to P_EOL with a sync flag set;
- CR and LF(0x0A) SHALL be ignored silently;
- any other byte SHALL raise o_err and stay in P_IDLE.
REQ-024 In P_ADDR, a hex digit SHALL be stored in a 4-bit address shadow, then the parser goes to P_DATA with the digit counter cleared.
REQ-025 In P_DATA, each hex digit SHALL shift into a 32-bit data shadow (shadow = shadow<<4 | nibble); after the 8th digit the parser goes to P_EOL.
REQ-026 In P_EOL, CR SHALL complete the command:
- sync flag set: o_sync pulses;
- otherwise: o_wr_addr/o_wr_data load from the shadows and o_wr_en pulses in the same cycle.
REQ-027 Completion outputs SHALL assert exactly 1 cycle after the o_byte_valid that carried the CR.
REQ-028 Any unexpected byte in P_ADDR, P_DATA or P_EOL SHALL pulse o_err, discard the shadows and return to P_IDLE; outputs SHALL NOT change.
REQ-029 A framing error while the parser is not in P_IDLE SHALL abort the command to P_IDLE, with a single o_err pulse.
REQ-030 o_wr_en, o_sync and o_err SHALL never assert for more than one cycle per event.

Reset
REQ-031 On i_rst high at a rising edge:
- RX FSM goes to R_IDLE and parser to P_IDLE;
- synchronizer flops are set to 1;
- o_byte_valid, o_wr_en, o_sync and o_err are 0;
- o_byte is 0x00, o_wr_addr is 0x0 and o_wr_data is 0x00000000.
REQ-032 Reset mid-byte or mid-command SHALL drop all partial state; a byte whose start bit preceded reset deassertion SHALL NOT be reported.

Verification
REQ-033 With CLKS_PER_BIT=8, send "W3DEADBEEF\r" -> one o_wr_en, o_wr_addr=0x3, o_wr_data=0xDEADBEEF, 1 cycle after the CR byte_valid; no o_err.
REQ-034 Send "S\r" -> exactly one o_sync pulse; o_wr_* unchanged from the previous value.
REQ-035 Send "W1123X" -> one o_err at 'X'; then "W10000002A\r" -> o_wr_data=0x0000002A, o_wr_addr=0x1.
REQ-036 Send byte 0x55 with the stop bit forced low -> o_err pulse, no o_byte_valid; hold line low for 40 bits, then send 'S','\r' -> one o_sync.
REQ-037 Low glitch of 2 cycles on an idle line -> no o_byte_valid and no o_err; assert i_rst during bit 4 of a byte -> all outputs reset values, no byte reported.
REQ-038 With the default CLKS_PER_BIT=434 at 115200 baud, ±2% baud skew on "Wa0000ffff\r" -> o_wr_addr=0xA, o_wr_data=0x0000FFFF.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver feeding an ASCII command parser: "W<a><dddddddd>\r" issues a
// register write, "S\r" requests a PPS re-sync.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_uart_rx,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte,
  output logic        o_wr_en,
  output logic [3:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_sync,
  output logic        o_err
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAIT_HI
  } rx_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_ADDR,
    P_DATA,
    P_EOL
  } p_state_t;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Letters of either case carry bit 6 and map A/a (x1) to 10 by adding 9.
  function automatic logic [3:0] hex_nib(input logic [7:0] c);
    return c[3:0] + (c[6] ? 4'd9 : 4'd0);
  endfunction

  // Synchronizer stages; rx_p2 is kept only for falling-edge detection
  logic rx_p0, rx_p1, rx_p2;
  logic rx_sync, rx_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= i_uart_rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign rx_sync = rx_p1;
  assign rx_fall = rx_p2 & ~rx_p1;

  rx_state_t   rx_state, rx_next;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        armed;
  logic        bit_tick, half_tick, bit_sample, stop_ok, frame_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) rx_state <= R_IDLE;
    else       rx_state <= rx_next;
  end

  // Reception is only armed once the line has idled high for a full bit after
  // reset, so a frame already in flight at reset release is never picked up.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:    if (armed && rx_fall) rx_next = R_START;
      R_START:   if (half_tick) rx_next = rx_sync ? R_IDLE : R_DATA;
      R_DATA:    if (bit_tick && (bit_idx == 3'd7)) rx_next = R_STOP;
      R_STOP:    if (bit_tick) rx_next = rx_sync ? R_IDLE : R_WAIT_HI;
      R_WAIT_HI: if (rx_sync) rx_next = R_IDLE;
      default:   rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    bit_tick   = (cnt == BIT_LAST);
    half_tick  = (cnt == HALF_LAST);
    bit_sample = (rx_state == R_DATA) && bit_tick;
    stop_ok    = (rx_state == R_STOP) && bit_tick && rx_sync;
    frame_err  = (rx_state == R_STOP) && bit_tick && !rx_sync;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      armed   <= 1'b0;
    end else begin
      if (rx_state != rx_next) begin
        cnt <= '0;
      end else begin
        case (rx_state)
          R_IDLE:         cnt <= (armed || !rx_sync) ? 16'd0 : cnt + 16'd1;
          R_START:        cnt <= cnt + 16'd1;
          R_DATA, R_STOP: cnt <= bit_tick ? 16'd0 : cnt + 16'd1;
          default:        cnt <= '0;
        endcase
      end
      if ((rx_state == R_IDLE) && rx_sync && bit_tick) armed <= 1'b1;
      if (rx_state == R_START)  bit_idx <= '0;
      else if (bit_sample)      bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (bit_sample) shift <= {rx_sync, shift[7:1]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_byte_valid <= 1'b0;
      o_byte       <= '0;
    end else begin
      o_byte_valid <= stop_ok;
      if (stop_ok) o_byte <= shift;
    end
  end

  // Command parser, advanced once per good byte
  p_state_t    p_state, p_next;
  logic [3:0]  addr_sh;
  logic [31:0] data_sh;
  logic [2:0]  dcnt;
  logic        sync_flag;
  logic        byte_hex, p_err, p_done;
  logic [3:0]  nib;

  assign byte_hex = is_hex(o_byte);
  assign nib      = hex_nib(o_byte);

  always_ff @(posedge i_clk) begin
    if (i_rst) p_state <= P_IDLE;
    else       p_state <= p_next;
  end

  always_comb begin
    p_next = p_state;
    if (frame_err) begin
      p_next = P_IDLE;
    end else if (o_byte_valid) begin
      case (p_state)
        P_IDLE: begin
          if (o_byte == CH_W)      p_next = P_ADDR;
          else if (o_byte == CH_S) p_next = P_EOL;
        end
        P_ADDR:  p_next = byte_hex ? P_DATA : P_IDLE;
        P_DATA: begin
          if (!byte_hex)          p_next = P_IDLE;
          else if (dcnt == 3'd7)  p_next = P_EOL;
        end
        P_EOL:   p_next = P_IDLE;
        default: p_next = P_IDLE;
      endcase
    end
  end

  always_comb begin
    p_err  = 1'b0;
    p_done = 1'b0;
    if (o_byte_valid && !frame_err) begin
      case (p_state)
        P_IDLE:  p_err = !((o_byte == CH_W) || (o_byte == CH_S) ||
                           (o_byte == CH_CR) || (o_byte == CH_LF));
        P_ADDR,
        P_DATA:  p_err = !byte_hex;
        P_EOL: begin
          p_err  = (o_byte != CH_CR);
          p_done = (o_byte == CH_CR);
        end
        default: p_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_flag <= 1'b0;
      dcnt      <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
      o_wr_en   <= 1'b0;
      o_sync    <= 1'b0;
      o_err     <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= p_done && !sync_flag;
      o_sync  <= p_done && sync_flag;
      o_err   <= frame_err || p_err;
      if (p_done && !sync_flag) begin
        o_wr_addr <= addr_sh;
        o_wr_data <= data_sh;
      end
      if (frame_err || p_err || p_done) begin
        sync_flag <= 1'b0;
        dcnt      <= '0;
        addr_sh   <= '0;
        data_sh   <= '0;
      end else if (o_byte_valid) begin
        case (p_state)
          P_IDLE: sync_flag <= (o_byte == CH_S);
          P_ADDR: begin
            addr_sh <= nib;
            dcnt    <= '0;
          end
          P_DATA: begin
            data_sh <= {data_sh[27:0], nib};
            dcnt    <= dcnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: a fast instance (8 clocks/bit) for the command
// set and two default-rate instances driven at +2% and -2% baud skew.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int CPB = 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst = 1'b1;
  logic rx = 1'b1, rx_a = 1'b1, rx_b = 1'b1;

  logic        bv, wr_en, sync_o, err;
  logic [7:0]  byte_o;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;

  logic        bv_a, wr_en_a, sync_a, err_a;
  logic [7:0]  byte_a;
  logic [3:0]  wr_addr_a;
  logic [31:0] wr_data_a;

  logic        bv_b, wr_en_b, sync_b, err_b;
  logic [7:0]  byte_b;
  logic [3:0]  wr_addr_b;
  logic [31:0] wr_data_b;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx),
    .o_byte_valid(bv), .o_byte(byte_o), .o_wr_en(wr_en),
    .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_sync(sync_o), .o_err(err)
  );

  uart_cmd_rx dut_plus (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_a),
    .o_byte_valid(bv_a), .o_byte(byte_a), .o_wr_en(wr_en_a),
    .o_wr_addr(wr_addr_a), .o_wr_data(wr_data_a), .o_sync(sync_a), .o_err(err_a)
  );

  uart_cmd_rx dut_minus (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_b),
    .o_byte_valid(bv_b), .o_byte(byte_b), .o_wr_en(wr_en_b),
    .o_wr_addr(wr_addr_b), .o_wr_data(wr_data_b), .o_sync(sync_b), .o_err(err_b)
  );

  logic [7:0]  q_byte[$];
  logic [35:0] q_wr[$];
  logic [35:0] q_sync[$];
  logic [7:0]  q_err[$];
  logic [35:0] q_wr_a[$];
  logic [35:0] q_wr_b[$];

  int n_vec = 0;
  int n_bad = 0;
  int bv_seen = 0;
  int err_seen = 0;
  int cyc = 0;
  logic prev_cr = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 95000) begin
      $display("FAIL watchdog: cycle %0d reached, want completion before 95000", cyc);
      $fatal(1, "bench timeout");
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_vec++;
    n_bad++;
    $display("FAIL %s: unexpected pulse (value 0x%0h), want none", name, act);
  endtask

  // Fast-instance monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bv) begin
        bv_seen++;
        if (q_byte.size() == 0) unexpected("byte_valid", byte_o);
        else check("byte", byte_o, q_byte.pop_front());
      end
      if (wr_en) begin
        check("wr_latency", prev_cr, 1);
        if (q_wr.size() == 0) unexpected("wr_en", {wr_addr, wr_data});
        else check("wr", {wr_addr, wr_data}, q_wr.pop_front());
      end
      if (sync_o) begin
        check("sync_latency", prev_cr, 1);
        if (q_sync.size() == 0) unexpected("sync", {wr_addr, wr_data});
        else check("sync_wr_held", {wr_addr, wr_data}, q_sync.pop_front());
      end
      if (err) begin
        err_seen++;
        if (q_err.size() == 0) unexpected("err", byte_o);
        else check("err_byte_held", byte_o, q_err.pop_front());
      end
      prev_cr = bv && (byte_o == 8'h0D);
    end else begin
      prev_cr = 1'b0;
    end
  end

  // Skewed-baud monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en_a) begin
        if (q_wr_a.size() == 0) unexpected("plus_wr_en", {wr_addr_a, wr_data_a});
        else check("plus_wr", {wr_addr_a, wr_data_a}, q_wr_a.pop_front());
      end
      if (err_a)  unexpected("plus_err", byte_a);
      if (sync_a) unexpected("plus_sync", byte_a);
      if (wr_en_b) begin
        if (q_wr_b.size() == 0) unexpected("minus_wr_en", {wr_addr_b, wr_data_b});
        else check("minus_wr", {wr_addr_b, wr_data_b}, q_wr_b.pop_front());
      end
      if (err_b)  unexpected("minus_err", byte_b);
      if (sync_b) unexpected("minus_sync", byte_b);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b);
    q_byte.push_back(b);
    send_frame(b, 1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  // Bit edges placed at round-down(k * period) cycles from the frame start.
  task automatic send_skew_byte(input int which, input logic [7:0] b, input int period_x100);
    logic [9:0] bits;
    int t0;
    bits = {1'b1, b, 1'b0};
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      set_line(which, bits[k]);
      while (cyc < t0 + ((k + 1) * period_x100) / 100) tick(1);
    end
  endtask

  task automatic send_skew_str(input int which, input int period_x100);
    string s;
    s = "Wa0000ffff\r";
    for (int i = 0; i < s.len(); i++) send_skew_byte(which, s[i], period_x100);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_valid"}, bv, 0);
    check({tag, "_byte"}, byte_o, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_sync"}, sync_o, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    int b0, e0;
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
    tick(20);

    q_wr.push_back({4'h3, 32'hDEADBEEF});
    send_str("W3DEADBEEF\r");
    tick(4);

    q_sync.push_back({4'h3, 32'hDEADBEEF});
    send_str("S\r");
    tick(4);
    @(negedge clk);
    check("hold_addr", wr_addr, 4'h3);
    check("hold_data", wr_data, 32'hDEADBEEF);

    q_err.push_back(8'h58);
    send_str("W1123X");
    q_wr.push_back({4'h1, 32'h0000002A});
    send_str("W10000002A\r");
    tick(4);

    send_str("\n\r");
    q_wr.push_back({4'hB, 32'h0123ABCD});
    send_str("Wb0123abcd\r");

    q_err.push_back(8'h35);
    send_str("S5");
    q_err.push_back(8'h47);
    send_str("WG");
    q_err.push_back(8'h51);
    send_str("Q");
    q_sync.push_back({4'hB, 32'h0123ABCD});
    send_str("S\r");

    // Framing error in idle, then a 40-bit break
    q_err.push_back(8'h0D);
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    tick(40 * CPB);
    rx = 1'b1;
    tick(2 * CPB);
    q_sync.push_back({4'hB, 32'h0123ABCD});
    send_str("S\r");

    // Framing error mid-command aborts it with one error
    send_str("W7");
    q_err.push_back(8'h37);
    send_frame(8'h41, 1'b0);
    rx = 1'b1;
    tick(2 * CPB);
    q_sync.push_back({4'hB, 32'h0123ABCD});
    send_str("S\r");

    // Short low glitch on an idle line
    b0 = bv_seen;
    e0 = err_seen;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(4 * CPB);
    check("glitch_byte_valid_count", bv_seen, b0);
    check("glitch_err_count", err_seen, e0);

    // Reset during bit 4 of a byte inside a partial command
    send_str("W5");
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      tick(CPB);
    end
    rx = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("midbyte_reset");
    tick(3);
    tick(3 * CPB);
    rx = 1'b1;
    tick(3 * CPB);
    q_sync.push_back({4'h0, 32'h00000000});
    send_str("S\r");
    q_wr.push_back({4'h9, 32'h00000001});
    send_str("W900000001\r");

    // Default-rate instances with +2% / -2% transmitter skew
    tick(500);
    q_wr_a.push_back({4'hA, 32'h0000FFFF});
    q_wr_b.push_back({4'hA, 32'h0000FFFF});
    fork
      send_skew_str(0, 434 * 102);
      send_skew_str(1, 434 * 98);
    join
    tick(2000);

    check("left_byte", q_byte.size(), 0);
    check("left_wr", q_wr.size(), 0);
    check("left_sync", q_sync.size(), 0);
    check("left_err", q_err.size(), 0);
    check("left_plus_wr", q_wr_a.size(), 0);
    check("left_minus_wr", q_wr_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
